l2_victim_buffer: RTL and testbench

Write-back victim buffer between the 8-way L2 cache and physical memory. It takes dirty 256-bit lines evicted by the L2 and queues them in a small FIFO, then drains them to physical memory in the background. It owns the single pmem port and arbitrates between L2 line fills (reads) and victim drains (writes). Lookups forward any buffered victim, so the L2 never refetches stale data from pmem.

---
 rtl/l2_victim_buffer.sv | 161 ++++++++++++++++
 tb/tb_l2_victim_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_victim_buffer.sv
// l2_victim_buffer
//   Write-back victim buffer between the 8-way L2 and physical memory.
//   Dirty lines evicted by the L2 are queued in a DEPTH-entry FIFO and
//   drained to pmem in the background. The block owns the pmem port and
//   arbitrates between L2 line fills (reads) and victim drains (writes).
//   Lookups forward the youngest buffered copy of a line. A fill whose
//   line is still buffered is held back until every copy of that line
//   has been drained.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   wb_req/wb_address/
//   wb_wdata/wb_resp      victim push from the L2 (wb_resp combinational)
//   rd_address/rd_hit/
//   rd_data               combinational victim lookup (youngest match wins)
//   l2_pmem_read/
//   l2_pmem_address/
//   l2_pmem_resp          L2 line-fill request and its completion
//   pmem_read/pmem_write/
//   pmem_address/
//   pmem_wdata/pmem_resp  physical memory port
module l2_victim_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wb_req,
    input  logic [15:0]  wb_address,
    input  logic [255:0] wb_wdata,
    output logic         wb_resp,
    input  logic [15:0]  rd_address,
    output logic         rd_hit,
    output logic [255:0] rd_data,
    input  logic         l2_pmem_read,
    input  logic [15:0]  l2_pmem_address,
    output logic         l2_pmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [PW:0]    count_q;
    logic [DEPTH-1:0] valid_q;
    logic [10:0]    tag_q  [DEPTH];
    logic [255:0]   data_q [DEPTH];

    logic           push;
    logic           pop;
    logic           fill_hazard;
    logic [PW-1:0]  idx;

    always_comb begin
        wb_resp = !reset && wb_req && (count_q != FULL);
        push    = wb_resp;
        pop     = (state_q == WRITE) && pmem_resp;
    end

    // Walk from head (oldest) toward tail so the last match is the youngest.
    always_comb begin
        rd_hit      = 1'b0;
        rd_data     = '0;
        fill_hazard = push && (wb_address[15:5] == l2_pmem_address[15:5]);
        idx         = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + i[PW-1:0];
            if (valid_q[idx] && (tag_q[idx] == rd_address[15:5])) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
            end
            if (valid_q[idx] && (tag_q[idx] == l2_pmem_address[15:5])) begin
                fill_hazard = 1'b1;
            end
        end
    end

    // The arbitration decision in IDLE treats a push landing this cycle as
    // already buffered: a drain can start on the next cycle, and a fill of
    // the line being pushed is never issued ahead of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (l2_pmem_read && !fill_hazard) begin
                        state_q <= READ;
                    end else if ((count_q != '0) || push) begin
                        state_q <= WRITE;
                    end
                end
                READ: begin
                    if (pmem_resp) state_q <= IDLE;
                end
                WRITE: begin
                    if (pmem_resp) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= wb_address[15:5];
            data_q[tail_q] <= wb_wdata;
        end
    end

    always_comb begin
        pmem_read    = (state_q == READ);
        pmem_write   = (state_q == WRITE);
        l2_pmem_resp = (state_q == READ) && pmem_resp;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == READ) begin
            pmem_address = l2_pmem_address;
        end else if (state_q == WRITE) begin
            pmem_address = {tag_q[head_q], 5'b0};
            pmem_wdata   = data_q[head_q];
        end
    end

endmodule

// File: tb/tb_l2_victim_buffer.sv
// tb_l2_victim_buffer
//   Directed scenarios plus a randomized run compared against a queue-based
//   reference model of the victim buffer and its pmem arbitration.
module tb_l2_victim_buffer;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [10:0]  tag;
        logic [255:0] data;
    } ent_t;

    logic         clk;
    logic         reset;
    logic         wb_req;
    logic [15:0]  wb_address;
    logic [255:0] wb_wdata;
    logic         wb_resp;
    logic [15:0]  rd_address;
    logic         rd_hit;
    logic [255:0] rd_data;
    logic         l2_pmem_read;
    logic [15:0]  l2_pmem_address;
    logic         l2_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;

    int n_checks;
    int n_fail;

    l2_victim_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_req          (wb_req),
        .wb_address      (wb_address),
        .wb_wdata        (wb_wdata),
        .wb_resp         (wb_resp),
        .rd_address      (rd_address),
        .rd_hit          (rd_hit),
        .rd_data         (rd_data),
        .l2_pmem_read    (l2_pmem_read),
        .l2_pmem_address (l2_pmem_address),
        .l2_pmem_resp    (l2_pmem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        wb_req          = 1'b0;
        wb_address      = '0;
        wb_wdata        = '0;
        rd_address      = '0;
        l2_pmem_read    = 1'b0;
        l2_pmem_address = '0;
        pmem_resp       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset           = 1'b1;
        wb_req          = 1'b1;
        wb_address      = 16'h0040;
        l2_pmem_read    = 1'b1;
        l2_pmem_address = 16'h0080;
        pmem_resp       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (wb_resp !== 1'b0) begin n_fail++; $display("FAIL reset_wb_resp: got %b expected 0", wb_resp); end
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %b expected 0", rd_hit); end
        n_checks++; if (rd_data !== 256'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b expected 0", pmem_write); end
        n_checks++; if (pmem_address !== 16'h0) begin n_fail++; $display("FAIL reset_pmem_address: got %h expected 0", pmem_address); end
        n_checks++; if (pmem_wdata !== 256'h0) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h expected 0", pmem_wdata); end
        n_checks++; if (l2_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_l2_pmem_resp: got %b expected 0", l2_pmem_resp); end
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_drain();
        logic [255:0] a;
        a = {8{$urandom()}};
        do_reset();
        @(negedge clk);
        wb_req = 1'b1; wb_address = 16'h1240; wb_wdata = a; rd_address = 16'h1240;
        #1;
        n_checks++; if (wb_resp !== 1'b1) begin n_fail++; $display("FAIL drain_wb_resp: got %b expected 1", wb_resp); end
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL drain_no_bypass: got %b expected 0", rd_hit); end
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        n_checks++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL drain_pmem_write: got %b expected 1", pmem_write); end
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL drain_pmem_read: got %b expected 0", pmem_read); end
        n_checks++; if (pmem_address !== 16'h1240) begin n_fail++; $display("FAIL drain_address: got %h expected 1240", pmem_address); end
        n_checks++; if (pmem_wdata !== a) begin n_fail++; $display("FAIL drain_wdata: got %h expected %h", pmem_wdata, a); end
        n_checks++; if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL drain_rd_hit: got %b expected 1", rd_hit); end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_checks++; if (l2_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL drain_l2_resp: got %b expected 0", l2_pmem_resp); end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL drain_done_write: got %b expected 0", pmem_write); end
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL drain_done_rd_hit: got %b expected 0", rd_hit); end
        @(negedge clk);
        #1;
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL drain_empty_idle: got %b expected 0", pmem_write); end
    endtask

    task automatic test_full();
        logic [255:0] d0, d1, d2;
        d0 = {8{$urandom()}}; d1 = {8{$urandom()}}; d2 = {8{$urandom()}};
        do_reset();
        @(negedge clk);
        wb_req = 1'b1; wb_address = 16'h0020; wb_wdata = d0;
        #1;
        n_checks++; if (wb_resp !== 1'b1) begin n_fail++; $display("FAIL full_push0: got %b expected 1", wb_resp); end
        @(negedge clk);
        wb_address = 16'h0040; wb_wdata = d1;
        #1;
        n_checks++; if (wb_resp !== 1'b1) begin n_fail++; $display("FAIL full_push1: got %b expected 1", wb_resp); end
        @(negedge clk);
        wb_address = 16'h0060; wb_wdata = d2;
        #1;
        n_checks++; if (wb_resp !== 1'b0) begin n_fail++; $display("FAIL full_blocked: got %b expected 0", wb_resp); end
        n_checks++; if (pmem_address !== 16'h0020) begin n_fail++; $display("FAIL full_head_addr: got %h expected 0020", pmem_address); end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_checks++; if (wb_resp !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle: got %b expected 0", wb_resp); end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        n_checks++; if (wb_resp !== 1'b1) begin n_fail++; $display("FAIL full_accept_after_pop: got %b expected 1", wb_resp); end
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        n_checks++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL full_second_write: got %b expected 1", pmem_write); end
        n_checks++; if (pmem_address !== 16'h0040) begin n_fail++; $display("FAIL full_second_addr: got %h expected 0040", pmem_address); end
        n_checks++; if (pmem_wdata !== d1) begin n_fail++; $display("FAIL full_second_data: got %h expected %h", pmem_wdata, d1); end
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (pmem_address !== 16'h0060) begin n_fail++; $display("FAIL full_third_addr: got %h expected 0060", pmem_address); end
        n_checks++; if (pmem_wdata !== d2) begin n_fail++; $display("FAIL full_third_data: got %h expected %h", pmem_wdata, d2); end
    endtask

    task automatic test_forwarding();
        logic [255:0] b, c;
        b = {8{$urandom()}}; c = {8{$urandom()}};
        do_reset();
        @(negedge clk);
        wb_req = 1'b1; wb_address = 16'h0100; wb_wdata = b; rd_address = 16'h0108;
        #1;
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle: got %b expected 0", rd_hit); end
        @(negedge clk);
        wb_wdata = c;
        #1;
        n_checks++; if (rd_data !== b) begin n_fail++; $display("FAIL fwd_first_copy: got %h expected %h", rd_data, b); end
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        n_checks++; if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_hit: got %b expected 1", rd_hit); end
        n_checks++; if (rd_data !== c) begin n_fail++; $display("FAIL fwd_youngest: got %h expected %h", rd_data, c); end
        n_checks++; if (pmem_wdata !== b) begin n_fail++; $display("FAIL fwd_head_oldest: got %h expected %h", pmem_wdata, b); end
        rd_address = 16'h0200;
        #1;
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss_hit: got %b expected 0", rd_hit); end
        n_checks++; if (rd_data !== 256'h0) begin n_fail++; $display("FAIL fwd_miss_data: got %h expected 0", rd_data); end
    endtask

    task automatic test_read_priority();
        logic [255:0] d;
        d = {8{$urandom()}};
        do_reset();
        @(negedge clk);
        wb_req = 1'b1; wb_address = 16'h0300; wb_wdata = d;
        l2_pmem_read = 1'b1; l2_pmem_address = 16'h0400;
        #1;
        n_checks++; if (wb_resp !== 1'b1) begin n_fail++; $display("FAIL prio_push: got %b expected 1", wb_resp); end
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        n_checks++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL prio_read_first: got %b expected 1", pmem_read); end
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL prio_no_write: got %b expected 0", pmem_write); end
        n_checks++; if (pmem_address !== 16'h0400) begin n_fail++; $display("FAIL prio_read_addr: got %h expected 0400", pmem_address); end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_checks++; if (l2_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL prio_l2_resp: got %b expected 1", l2_pmem_resp); end
        @(negedge clk);
        pmem_resp = 1'b0; l2_pmem_read = 1'b0;
        #1;
        n_checks++; if ((pmem_read | pmem_write) !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap: got %b%b expected 00", pmem_read, pmem_write); end
        @(negedge clk);
        #1;
        n_checks++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL prio_write_after: got %b expected 1", pmem_write); end
        n_checks++; if (pmem_address !== 16'h0300) begin n_fail++; $display("FAIL prio_write_addr: got %h expected 0300", pmem_address); end
    endtask

    task automatic test_hazard();
        logic [255:0] d;
        d = {8{$urandom()}};
        do_reset();
        @(negedge clk);
        wb_req = 1'b1; wb_address = 16'h0500; wb_wdata = d;
        l2_pmem_read = 1'b1; l2_pmem_address = 16'h0510;
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        n_checks++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL haz_write_first: got %b expected 1", pmem_write); end
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL haz_no_read: got %b expected 0", pmem_read); end
        n_checks++; if (pmem_address !== 16'h0500) begin n_fail++; $display("FAIL haz_write_addr: got %h expected 0500", pmem_address); end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_checks++; if (l2_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL haz_no_l2_resp: got %b expected 0", l2_pmem_resp); end
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL haz_read_after: got %b expected 1", pmem_read); end
        n_checks++; if (pmem_address !== 16'h0510) begin n_fail++; $display("FAIL haz_read_addr: got %h expected 0510", pmem_address); end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_checks++; if (l2_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL haz_l2_resp: got %b expected 1", l2_pmem_resp); end
        @(negedge clk);
        pmem_resp = 1'b0; l2_pmem_read = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        @(negedge clk);
        wb_req = 1'b1; wb_address = 16'h0700; wb_wdata = {8{$urandom()}};
        @(negedge clk);
        wb_address = 16'h0720; wb_wdata = {8{$urandom()}};
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        n_checks++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_write: got %b expected 1", pmem_write); end
        @(negedge clk);
        reset = 1'b1; rd_address = 16'h0700;
        #1;
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_write: got %b expected 0", pmem_write); end
        n_checks++; if (pmem_address !== 16'h0) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 0", pmem_address); end
        n_checks++; if (pmem_wdata !== 256'h0) begin n_fail++; $display("FAIL rst_mid_wdata: got %h expected 0", pmem_wdata); end
        n_checks++; if (rd_data !== 256'h0) begin n_fail++; $display("FAIL rst_mid_rd_data: got %h expected 0", rd_data); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hit0: got %b expected 0", rd_hit); end
        rd_address = 16'h0720;
        #1;
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hit1: got %b expected 0", rd_hit); end
        @(negedge clk);
        #1;
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got %b expected 0", pmem_write); end
    endtask

    // Reference: a FIFO of lines and the current pmem operation
    // (0 none, 1 fill, 2 drain), advanced once per clock from the rules.
    task automatic test_random();
        ent_t         q[$];
        int           op;
        logic         wb_acc, fill_done, hazard;
        logic         e_wb, e_hit, e_l2;
        logic [255:0] e_rdata, e_wdata;
        logic [15:0]  e_addr;
        do_reset();
        op = 0; wb_acc = 1'b0; fill_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (wb_acc) begin
                wb_req = 1'b0;
            end else if (!wb_req && ($urandom_range(0, 2) == 0)) begin
                wb_req     = 1'b1;
                wb_address = {11'($urandom_range(1, 4)), 5'($urandom())};
                wb_wdata   = {8{$urandom()}};
            end
            if (fill_done) begin
                l2_pmem_read = 1'b0;
            end else if (!l2_pmem_read && ($urandom_range(0, 3) == 0)) begin
                l2_pmem_read    = 1'b1;
                l2_pmem_address = {11'($urandom_range(1, 4)), 5'($urandom())};
            end
            rd_address = {11'($urandom_range(1, 4)), 5'($urandom())};
            pmem_resp  = (op != 0) && ($urandom_range(0, 2) == 0);
            #1;

            e_wb    = wb_req && (q.size() < DEPTH);
            e_hit   = 1'b0;
            e_rdata = '0;
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].tag == rd_address[15:5]) begin
                    e_hit = 1'b1; e_rdata = q[k].data; break;
                end
            end
            e_addr  = 16'h0;
            e_wdata = '0;
            if (op == 1) e_addr = l2_pmem_address;
            if (op == 2 && q.size() > 0) begin
                e_addr  = {q[0].tag, 5'b0};
                e_wdata = q[0].data;
            end
            e_l2 = (op == 1) && pmem_resp;

            n_checks++; if (wb_resp !== e_wb) begin n_fail++; $display("FAIL rnd_wb_resp cyc %0d: got %b expected %b", c, wb_resp, e_wb); end
            n_checks++; if (rd_hit !== e_hit) begin n_fail++; $display("FAIL rnd_rd_hit cyc %0d: got %b expected %b", c, rd_hit, e_hit); end
            n_checks++; if (rd_data !== e_rdata) begin n_fail++; $display("FAIL rnd_rd_data cyc %0d: got %h expected %h", c, rd_data, e_rdata); end
            n_checks++; if (pmem_read !== (op == 1)) begin n_fail++; $display("FAIL rnd_pmem_read cyc %0d: got %b expected %b", c, pmem_read, op == 1); end
            n_checks++; if (pmem_write !== (op == 2)) begin n_fail++; $display("FAIL rnd_pmem_write cyc %0d: got %b expected %b", c, pmem_write, op == 2); end
            n_checks++; if (pmem_address !== e_addr) begin n_fail++; $display("FAIL rnd_pmem_address cyc %0d: got %h expected %h", c, pmem_address, e_addr); end
            n_checks++; if (pmem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_pmem_wdata cyc %0d: got %h expected %h", c, pmem_wdata, e_wdata); end
            n_checks++; if (l2_pmem_resp !== e_l2) begin n_fail++; $display("FAIL rnd_l2_pmem_resp cyc %0d: got %b expected %b", c, l2_pmem_resp, e_l2); end

            hazard = e_wb && (wb_address[15:5] == l2_pmem_address[15:5]);
            foreach (q[k]) if (q[k].tag == l2_pmem_address[15:5]) hazard = 1'b1;
            fill_done = e_l2;
            if (op == 0) begin
                if (l2_pmem_read && !hazard) op = 1;
                else if (q.size() > 0 || e_wb) op = 2;
            end else if (pmem_resp) begin
                if (op == 2) void'(q.pop_front());
                op = 0;
            end
            if (e_wb) q.push_back('{tag: wb_address[15:5], data: wb_wdata});
            wb_acc = e_wb;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_drain();
        test_full();
        test_forwarding();
        test_read_priority();
        test_hazard();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
